// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
// Module   : simon_pkg
// Purpose  : Shared definitions for the Simon sequencing controller: FSM
//            state codes, default hold lengths and the 2-bit one-hot decoder.
// Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

    // State codes are visible on the debug 'state' port, so values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_SHOW  = 3'd2,
        ST_GAP   = 3'd3,
        ST_INPUT = 3'd4,
        ST_WIN   = 3'd5,
        ST_FAIL  = 3'd6
    } state_t;

    localparam int c_FAIL_TICKS_DEF = 3;
    localparam int c_WIN_TICKS_DEF  = 3;

    function automatic logic [3:0] onehot2(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/simon_press_capture.sv
`default_nettype none
// ============================================================================
// Module   : simon_press_capture
// Purpose  : Rising-edge detect on the decoded button level plus a one-deep
//            press latch. A fresh edge always wins over a same-cycle consume,
//            so a press arriving on the consuming cycle is kept for later.
// Ports    : clk, reset (async, active-high)
//            btn_valid, btn_val  - decoded button level / index
//            consume             - clear the latched press
//            pending, val        - latched press flag / index
// Revision : 1.0 - initial release
// ============================================================================
module simon_press_capture (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_valid,
    input  logic [1:0] btn_val,
    input  logic       consume,
    output logic       pending,
    output logic [1:0] val
);

    logic       r_prev_q;
    logic       r_pending_q;
    logic [1:0] r_val_q;
    logic       w_pending_d;
    logic [1:0] w_val_d;
    logic       w_rise;

    assign w_rise = btn_valid & ~r_prev_q;

    always_comb begin
        w_pending_d = r_pending_q;
        w_val_d     = r_val_q;
        if (w_rise) begin
            w_pending_d = 1'b1;
            w_val_d     = btn_val;
        end else if (consume) begin
            w_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_prev_q    <= 1'b0;
            r_pending_q <= 1'b0;
            r_val_q     <= 2'd0;
        end else begin
            r_prev_q    <= btn_valid;
            r_pending_q <= w_pending_d;
            r_val_q     <= w_val_d;
        end
    end

    assign pending = r_pending_q;
    assign val     = r_val_q;

endmodule
`default_nettype wire

// File: rtl/simon_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : simon_game_ctrl
// Purpose  : Simon sequencing controller. Grows the pattern one step per
//            round (LFSR sample written to RAM), plays it back on the LEDs,
//            then scores player presses against the stored pattern.
//            All state changes happen on cycles with tick=1.
// Ports    : clk, reset (async, active-high), tick (step enable)
//            btn_valid/btn_val - decoded buttons; lfsr_val - LFSR output
//            rd_data           - RAM read data (1 clk after rd_addr)
//            lfsr_en, write_en, wr_addr, wr_data, rd_addr - datapath control
//            led, error_led    - user outputs; state, level - debug
// Config   : define SIMON_TIMEOUT_EN to fail after TIMEOUT_TICKS idle ticks
//            in INPUT; without it INPUT waits indefinitely.
// Revision : 1.0 - initial release
// ============================================================================
module simon_game_ctrl
    import simon_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int AW         = 4,
    parameter int FAIL_TICKS = c_FAIL_TICKS_DEF,
    parameter int WIN_TICKS  = c_WIN_TICKS_DEF
`ifdef SIMON_TIMEOUT_EN
    ,
    parameter int TIMEOUT_TICKS = 5
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tick,
    input  logic          btn_valid,
    input  logic [1:0]    btn_val,
    input  logic [1:0]    lfsr_val,
    input  logic [1:0]    rd_data,
    output logic          lfsr_en,
    output logic          write_en,
    output logic [AW-1:0] wr_addr,
    output logic [1:0]    wr_data,
    output logic [AW-1:0] rd_addr,
    output logic [3:0]    led,
    output logic          error_led,
    output logic [2:0]    state,
    output logic [3:0]    level
);

    generate
        if (DEPTH < 1 || DEPTH > 15 || DEPTH > (1 << AW)) begin : g_depth_check
            $error("simon_game_ctrl: DEPTH must be in 1..15 and not exceed 2**AW");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Press capture
    // ------------------------------------------------------------------
    logic       w_pending;
    logic [1:0] w_press_val;
    logic       w_consume;

    simon_press_capture u_press (
        .clk       (clk),
        .reset     (reset),
        .btn_valid (btn_valid),
        .btn_val   (btn_val),
        .consume   (w_consume),
        .pending   (w_pending),
        .val       (w_press_val)
    );

    // ------------------------------------------------------------------
    // FSM state and registered outputs
    // ------------------------------------------------------------------
    state_t        r_state_q,    w_state_d;
    logic [3:0]    r_level_q,    w_level_d;
    logic [AW-1:0] r_idx_q,      w_idx_d;
    logic [AW-1:0] r_rd_addr_q,  w_rd_addr_d;
    logic [7:0]    r_hold_q,     w_hold_d;
    logic [AW-1:0] r_wr_addr_q,  w_wr_addr_d;
    logic [1:0]    r_wr_data_q,  w_wr_data_d;
    logic          r_write_en_q, w_write_en_d;
    logic          r_lfsr_en_q,  w_lfsr_en_d;
    logic [3:0]    r_led_q,      w_led_d;
    logic          r_error_q,    w_error_d;
    logic [AW-1:0] w_last_idx;

    assign w_last_idx = AW'(r_level_q - 4'd1);

    always_comb begin
        w_state_d    = r_state_q;
        w_level_d    = r_level_q;
        w_idx_d      = r_idx_q;
        w_rd_addr_d  = r_rd_addr_q;
        w_hold_d     = r_hold_q;
        w_wr_addr_d  = r_wr_addr_q;
        w_wr_data_d  = r_wr_data_q;
        w_write_en_d = 1'b0;
        w_lfsr_en_d  = 1'b0;
        // Presses made while the pattern plays back are discarded.
        w_consume    = (r_state_q == ST_SHOW) || (r_state_q == ST_GAP);

        if (tick) begin
            case (r_state_q)
                ST_IDLE: begin
                    if (w_pending) begin
                        // Start press: consumed, not scored. The write/LFSR
                        // strobes are registered so they fire during GEN.
                        w_consume    = 1'b1;
                        w_level_d    = 4'd1;
                        w_state_d    = ST_GEN;
                        w_wr_addr_d  = '0;
                        w_wr_data_d  = lfsr_val;
                        w_write_en_d = 1'b1;
                        w_lfsr_en_d  = 1'b1;
                    end
                end
                ST_GEN: begin
                    w_consume   = 1'b1;
                    w_idx_d     = '0;
                    w_rd_addr_d = '0;
                    w_state_d   = ST_SHOW;
                end
                ST_SHOW: begin
                    w_state_d = ST_GAP;
                end
                ST_GAP: begin
                    if (r_idx_q == w_last_idx) begin
                        w_idx_d     = '0;
                        w_rd_addr_d = '0;
                        w_hold_d    = 8'd0;
                        w_state_d   = ST_INPUT;
                    end else begin
                        w_idx_d     = r_idx_q + AW'(1);
                        w_rd_addr_d = r_rd_addr_q + AW'(1);
                        w_state_d   = ST_SHOW;
                    end
                end
                ST_INPUT: begin
                    if (w_pending) begin
                        w_consume = 1'b1;
                        w_hold_d  = 8'd0;
                        if (w_press_val != rd_data) begin
                            w_state_d = ST_FAIL;
                        end else if (r_idx_q != w_last_idx) begin
                            w_idx_d     = r_idx_q + AW'(1);
                            w_rd_addr_d = r_rd_addr_q + AW'(1);
                        end else if (r_level_q == 4'(DEPTH)) begin
                            w_state_d = ST_WIN;
                        end else begin
                            // New step goes to the address just past the
                            // current pattern, i.e. the old level value.
                            w_level_d    = r_level_q + 4'd1;
                            w_state_d    = ST_GEN;
                            w_wr_addr_d  = AW'(r_level_q);
                            w_wr_data_d  = lfsr_val;
                            w_write_en_d = 1'b1;
                            w_lfsr_en_d  = 1'b1;
                        end
                    end
`ifdef SIMON_TIMEOUT_EN
                    else if (r_hold_q == 8'(TIMEOUT_TICKS - 1)) begin
                        w_hold_d  = 8'd0;
                        w_state_d = ST_FAIL;
                    end else begin
                        w_hold_d = r_hold_q + 8'd1;
                    end
`endif
                end
                ST_WIN: begin
                    if (r_hold_q == 8'(WIN_TICKS - 1)) begin
                        w_state_d   = ST_IDLE;
                        w_level_d   = 4'd0;
                        w_idx_d     = '0;
                        w_rd_addr_d = '0;
                        w_hold_d    = 8'd0;
                    end else begin
                        w_hold_d = r_hold_q + 8'd1;
                    end
                end
                ST_FAIL: begin
                    if (r_hold_q == 8'(FAIL_TICKS - 1)) begin
                        w_state_d   = ST_IDLE;
                        w_level_d   = 4'd0;
                        w_idx_d     = '0;
                        w_rd_addr_d = '0;
                        w_hold_d    = 8'd0;
                    end else begin
                        w_hold_d = r_hold_q + 8'd1;
                    end
                end
                default: begin
                    w_state_d = ST_IDLE;
                    w_level_d = 4'd0;
                end
            endcase
        end

        // LED outputs follow the next state so they line up with 'state'.
        // In SHOW the LED is blanked on the entry cycle because rd_data
        // still reflects the previous address.
        case (w_state_d)
            ST_SHOW:  w_led_d = (r_state_q == ST_SHOW) ? onehot2(rd_data) : 4'b0000;
            ST_INPUT: w_led_d = btn_valid ? onehot2(btn_val) : 4'b0000;
            ST_WIN:   w_led_d = 4'b1111;
            default:  w_led_d = 4'b0000;
        endcase
        w_error_d = (w_state_d == ST_FAIL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state_q    <= ST_IDLE;
            r_level_q    <= 4'd0;
            r_idx_q      <= '0;
            r_rd_addr_q  <= '0;
            r_hold_q     <= 8'd0;
            r_wr_addr_q  <= '0;
            r_wr_data_q  <= 2'd0;
            r_write_en_q <= 1'b0;
            r_lfsr_en_q  <= 1'b0;
            r_led_q      <= 4'd0;
            r_error_q    <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_level_q    <= w_level_d;
            r_idx_q      <= w_idx_d;
            r_rd_addr_q  <= w_rd_addr_d;
            r_hold_q     <= w_hold_d;
            r_wr_addr_q  <= w_wr_addr_d;
            r_wr_data_q  <= w_wr_data_d;
            r_write_en_q <= w_write_en_d;
            r_lfsr_en_q  <= w_lfsr_en_d;
            r_led_q      <= w_led_d;
            r_error_q    <= w_error_d;
        end
    end

    assign lfsr_en   = r_lfsr_en_q;
    assign write_en  = r_write_en_q;
    assign wr_addr   = r_wr_addr_q;
    assign wr_data   = r_wr_data_q;
    assign rd_addr   = r_rd_addr_q;
    assign led       = r_led_q;
    assign error_led = r_error_q;
    assign state     = r_state_q;
    assign level     = r_level_q;

endmodule
`default_nettype wire

// File: tb/tb_simon_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_simon_game_ctrl
// Purpose  : Self-checking bench for simon_game_ctrl. Provides a sequence
//            RAM model and a pattern model (array of stored colours plus the
//            current level) and plays directed games with random colours.
// Revision : 1.0 - initial release
// ============================================================================
module tb_simon_game_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_GEN   = 1;
    localparam int S_SHOW  = 2;
    localparam int S_GAP   = 3;
    localparam int S_INPUT = 4;
    localparam int S_WIN   = 5;
    localparam int S_FAIL  = 6;
    localparam int DEPTH   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic       btn_valid;
    logic [1:0] btn_val;
    logic [1:0] lfsr_val;
    logic [1:0] rd_data;
    logic       lfsr_en;
    logic       write_en;
    logic [3:0] wr_addr;
    logic [1:0] wr_data;
    logic [3:0] rd_addr;
    logic [3:0] led;
    logic       error_led;
    logic [2:0] state;
    logic [3:0] level;

    simon_game_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .btn_valid (btn_valid),
        .btn_val   (btn_val),
        .lfsr_val  (lfsr_val),
        .rd_data   (rd_data),
        .lfsr_en   (lfsr_en),
        .write_en  (write_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .rd_addr   (rd_addr),
        .led       (led),
        .error_led (error_led),
        .state     (state),
        .level     (level)
    );

    always #5 clk = ~clk;

    // Sequence RAM: one-cycle read latency.
    logic [1:0] mem [0:15];
    always @(posedge clk) begin
        if (write_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    // Strobe monitor.
    int         wr_cnt = 0;
    int         lfsr_cnt = 0;
    logic [3:0] wr_addr_seen = 4'd0;
    logic [1:0] wr_data_seen = 2'd0;
    always @(posedge clk) begin
        if (write_en) begin
            wr_cnt       <= wr_cnt + 1;
            wr_addr_seen <= wr_addr;
            wr_data_seen <= wr_data;
        end
        if (lfsr_en) lfsr_cnt <= lfsr_cnt + 1;
    end

    // Pattern model.
    logic [1:0] m_seq [0:15];
    int         exp_wr = 0;
    int         n_checks = 0;
    int         n_err = 0;

    function automatic logic [3:0] oh(input logic [1:0] v);
        logic [3:0] r;
        r    = 4'b0000;
        r[v] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk) tick = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic press(input logic [1:0] v, input bit in_input);
        @(negedge clk);
        btn_val   = v;
        btn_valid = 1'b1;
        repeat (3) @(negedge clk);
        if (in_input) chk("led_mirror", led, oh(v));
        btn_valid = 1'b0;
        @(negedge clk);
    endtask

    // Expect GEN at level L with exactly one new write of the colour the
    // model recorded for step L-1.
    task automatic check_gen(input int L);
        exp_wr++;
        chk("gen_state", state, S_GEN);
        chk("gen_level", level, L);
        chk("gen_wr_cnt", wr_cnt, exp_wr);
        chk("gen_lfsr_cnt", lfsr_cnt, exp_wr);
        chk("gen_wr_addr", wr_addr_seen, L - 1);
        chk("gen_wr_data", wr_data_seen, m_seq[L-1]);
        chk("gen_write_en_low", write_en, 0);
    endtask

    task automatic playback(input int L);
        for (int i = 0; i < L; i++) begin
            step();
            chk("show_state", state, S_SHOW);
            chk("show_led", led, oh(m_seq[i]));
            step();
            chk("gap_state", state, S_GAP);
            chk("gap_led", led, 0);
        end
        step();
        chk("input_state", state, S_INPUT);
        chk("input_rd_addr", rd_addr, 0);
    endtask

    initial begin
        for (int a = 0; a < 16; a++) mem[a] = 2'd0;
        reset     = 1'b1;
        tick      = 1'b0;
        btn_valid = 1'b0;
        btn_val   = 2'd0;
        lfsr_val  = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_state", state, S_IDLE);
        chk("rst_level", level, 0);
        chk("rst_led", led, 0);
        chk("rst_error_led", error_led, 0);
        chk("rst_write_en", write_en, 0);
        chk("rst_lfsr_en", lfsr_en, 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);

        // Reset while in SHOW.
        lfsr_val = 2'($urandom);
        m_seq[0] = lfsr_val;
        press(2'($urandom), 1'b0);
        step();
        check_gen(1);
        step();
        chk("pre_rst_state", state, S_SHOW);
        @(negedge clk) reset = 1'b1;
        #1;
        chk("midrst_state", state, S_IDLE);
        chk("midrst_led", led, 0);
        chk("midrst_write_en", write_en, 0);
        chk("midrst_level", level, 0);
        @(negedge clk) reset = 1'b0;
        repeat (2) @(negedge clk);

        // Full winning game; first colour forced to 2 (LED 4'b0100).
        lfsr_val = 2'd2;
        m_seq[0] = 2'd2;
        press(2'($urandom), 1'b0);
        step();
        check_gen(1);
        for (int L = 1; L <= DEPTH; L++) begin
            playback(L);
            for (int i = 0; i < L; i++) begin
                if (i == L - 1 && L < DEPTH) begin
                    lfsr_val = 2'($urandom);
                    m_seq[L] = lfsr_val;
                end
                press(m_seq[i], 1'b1);
                step();
                if (i < L - 1) begin
                    chk("in_progress_state", state, S_INPUT);
                    chk("in_progress_rd_addr", rd_addr, i + 1);
                end else if (L == DEPTH) begin
                    chk("win_state", state, S_WIN);
                    chk("win_led", led, 4'hF);
                end else begin
                    check_gen(L + 1);
                end
            end
        end
        step();
        chk("win_hold1", state, S_WIN);
        step();
        chk("win_hold2", state, S_WIN);
        chk("win_hold2_led", led, 4'hF);
        step();
        chk("win_end_state", state, S_IDLE);
        chk("win_end_level", level, 0);
        chk("win_end_led", led, 0);

        // Game with presses during playback, a tick-coincident press and a
        // wrong press in round 2 (stored 1, pressed 3).
        lfsr_val = 2'($urandom);
        m_seq[0] = lfsr_val;
        press(2'($urandom), 1'b0);
        step();
        check_gen(1);
        step();
        chk("b_show_state", state, S_SHOW);
        press(2'($urandom), 1'b0);
        step();
        chk("b_gap_state", state, S_GAP);
        press(2'($urandom), 1'b0);
        step();
        chk("b_input_state", state, S_INPUT);
        step();
        chk("b_wait_state", state, S_INPUT);
        chk("b_wait_rd_addr", rd_addr, 0);
        chk("b_wait_level", level, 1);
        lfsr_val = 2'd1;
        m_seq[1] = 2'd1;
        @(negedge clk);
        btn_val   = m_seq[0];
        btn_valid = 1'b1;
        tick      = 1'b1;
        @(negedge clk) tick = 1'b0;
        repeat (3) @(negedge clk);
        chk("coinc_not_scored", state, S_INPUT);
        chk("coinc_level", level, 1);
        btn_valid = 1'b0;
        step();
        check_gen(2);
        playback(2);
        press(m_seq[0], 1'b1);
        step();
        chk("r2_first_ok", state, S_INPUT);
        press(2'd3, 1'b1);
        step();
        chk("fail_state", state, S_FAIL);
        chk("fail_error_led", error_led, 1);
        step();
        step();
        chk("fail_hold_state", state, S_FAIL);
        chk("fail_hold_error_led", error_led, 1);
        step();
        chk("fail_end_state", state, S_IDLE);
        chk("fail_end_level", level, 0);
        chk("fail_end_error_led", error_led, 0);

        // No press in INPUT for five ticks.
        lfsr_val = 2'($urandom);
        m_seq[0] = lfsr_val;
        press(2'($urandom), 1'b0);
        step();
        check_gen(1);
        playback(1);
        repeat (4) step();
        chk("idle4_state", state, S_INPUT);
        step();
`ifdef SIMON_TIMEOUT_EN
        chk("timeout_state", state, S_FAIL);
`else
        chk("no_timeout_state", state, S_INPUT);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
